// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared constants and state encoding for the fully connected layer engine
package fc_pkg;

  localparam int DEF_FM_LEN = 384;
  localparam int DEF_N_OUT  = 10;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_BEATS  = DEF_FM_LEN / 8;

  // Eight 16-bit signed products summed need 3 extra bits of headroom.
  localparam int PSUM_W = 19;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } fc_state_t;

endpackage

// File: rtl/fc_dot8.sv
// rtl/fc_dot8.sv - 8-lane signed 8x8 multiply with adder tree and one output register
module fc_dot8
  import fc_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [63:0]              a,
  input  logic [63:0]              b,
  output logic signed [PSUM_W-1:0] sum
);

  logic signed [PSUM_W-1:0] sum_d;

  // Operands are widened to 16 bits before the multiply so the product is not truncated.
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < 8; k++) begin
      sum_d = sum_d + PSUM_W'(16'($signed(a[8*k +: 8])) * 16'($signed(b[8*k +: 8])));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else begin
      sum <= sum_d;
    end
  end

endmodule

// File: rtl/fc_compute.sv
// rtl/fc_compute.sv - fully connected layer engine: FSM, address generation and accumulator
module fc_compute
  import fc_pkg::*;
#(
  parameter int FM_LEN = DEF_FM_LEN,
  parameter int N_OUT  = DEF_N_OUT,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_fc_start,
  output logic [15:0]      o_fc_fm_addr,
  input  logic [63:0]      i_fc_fm_data,
  output logic [15:0]      o_w_addr,
  input  logic [63:0]      i_w_data,
  output logic             o_result_valid,
  output logic [3:0]       o_result_idx,
  output logic [ACC_W-1:0] o_result_data,
  output logic             o_busy,
  output logic             o_done
);

  localparam int BEATS = FM_LEN / 8;

  fc_state_t                state_q, state_d;
  logic [15:0]              beat_q, beat_d;
  logic [3:0]               n_q, n_d;
  logic                     v1_q, v2_q;
  logic signed [PSUM_W-1:0] psum;
  logic signed [ACC_W-1:0]  acc_q, acc_next;
  logic [15:0]              fm_addr_d, w_addr_d;

  fc_dot8 u_dot8 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (i_fc_fm_data),
    .b     (i_w_data),
    .sum   (psum)
  );

  // beat_q counts issued beats in RUN and elapsed cycles in DRAIN.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    n_d     = n_q;
    case (state_q)
      IDLE: begin
        if (i_fc_start) begin
          state_d = RUN;
          beat_d  = '0;
          n_d     = '0;
        end
      end
      RUN: begin
        if (beat_q == 16'(BEATS - 1)) begin
          state_d = DRAIN;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 16'd1;
        end
      end
      DRAIN: begin
        if (beat_q == 16'd1) begin
          state_d = OUT;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 16'd1;
        end
      end
      OUT: begin
        beat_d = '0;
        if (n_q == 4'(N_OUT - 1)) begin
          state_d = DONE;
          n_d     = '0;
        end else begin
          state_d = RUN;
          n_d     = n_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fm_addr_d = {beat_d[12:0], 3'b000};
  assign w_addr_d  = 16'(n_d) * 16'(BEATS) + beat_d;
  assign acc_next  = v2_q ? acc_q + ACC_W'(psum) : acc_q;

  // v1/v2 track a beat through the ROM read and the dot-product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      n_q            <= '0;
      v1_q           <= 1'b0;
      v2_q           <= 1'b0;
      acc_q          <= '0;
      o_fc_fm_addr   <= '0;
      o_w_addr       <= '0;
      o_result_valid <= 1'b0;
      o_result_idx   <= '0;
      o_result_data  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      n_q     <= n_d;
      v1_q    <= (state_q == RUN);
      v2_q    <= v1_q;
      if (state_d == RUN) begin
        o_fc_fm_addr <= fm_addr_d;
        o_w_addr     <= w_addr_d;
      end else begin
        o_fc_fm_addr <= '0;
        o_w_addr     <= '0;
      end
      if (state_d == RUN && state_q != RUN) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_next;
      end
      o_result_valid <= (state_d == OUT);
      if (state_d == OUT) begin
        o_result_idx  <= n_q;
        o_result_data <= acc_next;
      end
    end
  end

  assign o_busy = (state_q == RUN) || (state_q == DRAIN) || (state_q == OUT);
  assign o_done = (state_q == DONE);

endmodule

// File: tb/tb_fc_compute.sv
// tb/tb_fc_compute.sv - scoreboard testbench for fc_compute with synchronous ROM models
module tb_fc_compute;

  localparam int FM_LEN = 384;
  localparam int N_OUT  = 10;
  localparam int ACC_W  = 32;
  localparam int BEATS  = FM_LEN / 8;
  localparam int NCYC   = BEATS + 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             i_fc_start = 1'b0;
  logic [15:0]      o_fc_fm_addr;
  logic [63:0]      i_fc_fm_data = '0;
  logic [15:0]      o_w_addr;
  logic [63:0]      i_w_data = '0;
  logic             o_result_valid;
  logic [3:0]       o_result_idx;
  logic [ACC_W-1:0] o_result_data;
  logic             o_busy;
  logic             o_done;

  typedef struct {
    int idx;
    int data;
    int cyc;
  } exp_t;

  byte  fm_mem [FM_LEN];
  byte  w_mem  [N_OUT*FM_LEN];
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int base = 0;
  int done_cnt = 0;
  int run_done0 = 0;
  bit active = 1'b0;

  fc_compute #(.FM_LEN(FM_LEN), .N_OUT(N_OUT), .ACC_W(ACC_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_fc_start     (i_fc_start),
    .o_fc_fm_addr   (o_fc_fm_addr),
    .i_fc_fm_data   (i_fc_fm_data),
    .o_w_addr       (o_w_addr),
    .i_w_data       (i_w_data),
    .o_result_valid (o_result_valid),
    .o_result_idx   (o_result_idx),
    .o_result_data  (o_result_data),
    .o_busy         (o_busy),
    .o_done         (o_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int k = 0; k < 8; k++) begin
      i_fc_fm_data[8*k +: 8] <= (int'(o_fc_fm_addr) + k < FM_LEN) ? fm_mem[int'(o_fc_fm_addr) + k] : 8'sd0;
      i_w_data[8*k +: 8]     <= (int'(o_w_addr) < N_OUT*BEATS) ? w_mem[int'(o_w_addr)*8 + k] : 8'sd0;
    end
  end

  always @(negedge clk) begin
    int   c;
    int   efm;
    int   ew;
    exp_t e;
    c = cyc - base;
    if (active && rst_n) begin
      n_cmp++;
      if (o_busy !== ((c >= 0 && c < N_OUT*NCYC) ? 1'b1 : 1'b0)) begin
        n_bad++;
        $display("FAIL busy c=%0d got %0b", c, o_busy);
      end
      if (c >= 0 && c < N_OUT*NCYC && (c % NCYC) < BEATS) begin
        efm = 8 * (c % NCYC);
        ew  = (c / NCYC) * BEATS + (c % NCYC);
      end else begin
        efm = 0;
        ew  = 0;
      end
      n_cmp++;
      if (int'(o_fc_fm_addr) != efm) begin
        n_bad++;
        $display("FAIL fm_addr c=%0d got %0d want %0d", c, o_fc_fm_addr, efm);
      end
      n_cmp++;
      if (int'(o_w_addr) != ew) begin
        n_bad++;
        $display("FAIL w_addr c=%0d got %0d want %0d", c, o_w_addr, ew);
      end
    end
    if (o_result_valid) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid c=%0d idx %0d data %0d", c, o_result_idx, $signed(o_result_data));
      end else begin
        e = sb.pop_front();
        if (int'(o_result_idx) != e.idx) begin
          n_bad++;
          $display("FAIL result_idx got %0d want %0d", o_result_idx, e.idx);
        end
        n_cmp++;
        if ($signed(o_result_data) != e.data) begin
          n_bad++;
          $display("FAIL result_data idx %0d got %0d want %0d", e.idx, $signed(o_result_data), e.data);
        end
        n_cmp++;
        if (c != e.cyc) begin
          n_bad++;
          $display("FAIL result_cycle idx %0d got %0d want %0d", e.idx, c, e.cyc);
        end
      end
    end
    if (o_done) begin
      done_cnt++;
      n_cmp++;
      if (c != N_OUT*NCYC) begin
        n_bad++;
        $display("FAIL done_cycle got %0d want %0d", c, N_OUT*NCYC);
      end
    end
  end

  task automatic load_pattern(input int kind);
    for (int i = 0; i < FM_LEN; i++) begin
      case (kind)
        0:       fm_mem[i] = 8'sd1;
        1, 2:    fm_mem[i] = -8'sd128;
        3:       fm_mem[i] = byte'(i % 8);
        default: fm_mem[i] = byte'($urandom);
      endcase
    end
    for (int n = 0; n < N_OUT; n++) begin
      for (int i = 0; i < FM_LEN; i++) begin
        case (kind)
          0:       w_mem[n*FM_LEN + i] = 8'sd1;
          1:       w_mem[n*FM_LEN + i] = -8'sd128;
          2:       w_mem[n*FM_LEN + i] = 8'sd127;
          3:       w_mem[n*FM_LEN + i] = byte'(n + 1);
          default: w_mem[n*FM_LEN + i] = byte'($urandom);
        endcase
      end
    end
  endtask

  task automatic start_run();
    longint s;
    for (int n = 0; n < N_OUT; n++) begin
      s = 0;
      for (int i = 0; i < FM_LEN; i++) s += int'(fm_mem[i]) * int'(w_mem[n*FM_LEN + i]);
      sb.push_back('{idx: n, data: int'(s), cyc: n*NCYC + BEATS + 2});
    end
    run_done0 = done_cnt;
    @(posedge clk);
    #1 i_fc_start = 1'b1;
    @(posedge clk);
    #1 i_fc_start = 1'b0;
    base   = cyc;
    active = 1'b1;
  endtask

  task automatic wait_done(input string name);
    for (int t = 0; t < N_OUT*NCYC + 100 && done_cnt == run_done0; t++) @(posedge clk);
    n_cmp++;
    if (done_cnt == run_done0) begin
      n_bad++;
      $display("FAIL %s timeout waiting for o_done", name);
    end
    repeat (8) @(posedge clk);
    #1;
    n_cmp++;
    if (done_cnt != run_done0 + 1) begin
      n_bad++;
      $display("FAIL %s done_count got %0d want 1", name, done_cnt - run_done0);
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s missing_results got %0d left want 0", name, sb.size());
    end
    sb.delete();
    active = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    n_cmp++;
    if ({o_fc_fm_addr, o_w_addr, o_result_valid, o_result_idx, o_result_data, o_busy, o_done} !== '0) begin
      n_bad++;
      $display("FAIL %s outputs_zero got addr %0d waddr %0d v %0b idx %0d data %0d busy %0b done %0b",
               name, o_fc_fm_addr, o_w_addr, o_result_valid, o_result_idx, o_result_data, o_busy, o_done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("idle");
  endtask

  task automatic test_ones();
    load_pattern(0);
    start_run();
    wait_done("ones");
  endtask

  task automatic test_extremes();
    load_pattern(1);
    start_run();
    wait_done("neg_neg");
    load_pattern(2);
    start_run();
    wait_done("neg_pos");
  endtask

  task automatic test_lane_order();
    load_pattern(3);
    start_run();
    wait_done("lanes");
  endtask

  task automatic test_start_ignored();
    load_pattern(3);
    start_run();
    repeat (20) @(posedge clk);
    #1 i_fc_start = 1'b1;
    @(posedge clk);
    #1 i_fc_start = 1'b0;
    repeat (N_OUT*NCYC - 21) @(posedge clk);
    #1 i_fc_start = 1'b1;
    @(posedge clk);
    #1 i_fc_start = 1'b0;
    wait_done("start_ignored");
  endtask

  task automatic test_reset_mid();
    load_pattern(4);
    start_run();
    repeat (130) @(posedge clk);
    #1 active = 1'b0;
    rst_n = 1'b0;
    #1 check_outputs_zero("reset_mid");
    sb.delete();
    repeat (5) @(posedge clk);
    #1 check_outputs_zero("reset_hold");
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    start_run();
    wait_done("after_reset");
  endtask

  task automatic test_back_to_back();
    load_pattern(4);
    start_run();
    wait_done("random_a");
    start_run();
    wait_done("random_b");
  endtask

  initial begin
    test_reset();
    test_ones();
    test_extremes();
    test_lane_order();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
